// File: rtl/sevenseg_scan_display.sv
// Time-multiplexed common-anode seven-segment scanner with per-frame input snapshot.
// Optional build macro: SEVENSEG_LEADING_ZERO_BLANK_EN suppresses leading zero digits.
module sevenseg_scan_display #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIGITS*4-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      div_cnt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [DIGITS*4-1:0]   shadow, shadow_nxt;
  logic [DIGITS-1:0]     dp_shadow, dp_shadow_nxt;
  logic                  tick;
  logic                  running;

  logic [3:0]            nib;
  logic                  dp_cur;
  logic [DIGITS-1:0]     an_onehot;
  logic                  lz_blank;
  logic                  show;
  logic [DIGITS-1:0]     an_act;
  logic [6:0]            seg_act;
  logic                  dp_act;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign tick    = (div_cnt == CNT_MAX);
  assign running = (state == SCAN);

  // refresh divider
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // scan state, digit index and frame snapshot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      shadow    <= '0;
      dp_shadow <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      shadow    <= shadow_nxt;
      dp_shadow <= dp_shadow_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    shadow_nxt    = shadow;
    dp_shadow_nxt = dp_shadow;
    case (state)
      IDLE: begin
        if (tick) begin
          state_nxt     = SCAN;
          idx_nxt       = '0;
          shadow_nxt    = digits;
          dp_shadow_nxt = dp_in;
        end
      end
      SCAN: begin
        if (tick) begin
          if (idx == IDX_MAX) begin
            // frame boundary: the only point where new input becomes visible
            idx_nxt       = '0;
            shadow_nxt    = digits;
            dp_shadow_nxt = dp_in;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // output decode of the current slot
  always_comb begin
    nib       = 4'h0;
    dp_cur    = 1'b0;
    an_onehot = '0;
    lz_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib          = shadow[i*4 +: 4];
        dp_cur       = dp_shadow[i];
        an_onehot[i] = 1'b1;
      end
    end
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
    begin
      logic zero_above;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        zero_above = zero_above && (shadow[i*4 +: 4] == 4'h0);
        if ((idx == IDX_W'(i)) && zero_above) begin
          lz_blank = 1'b1;
        end
      end
    end
`endif
    show    = running && !blank && !lz_blank;
    an_act  = show ? an_onehot : '0;
    seg_act = show ? hex7(nib) : 7'h00;
    dp_act  = show && dp_cur;
  end

  assign an  = (ACTIVE_LOW != 0) ? ~an_act  : an_act;
  assign seg = (ACTIVE_LOW != 0) ? ~seg_act : seg_act;
  assign dp  = (ACTIVE_LOW != 0) ? ~dp_act  : dp_act;

endmodule

// File: tb/tb_sevenseg_scan_display.sv
// Randomized bench for sevenseg_scan_display against a cycle-count based display model.
module tb_sevenseg_scan_display;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic        blank;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int tests = 0;
  int fails = 0;

  // model state: edges since reset release, refresh ticks seen, captured frame
  int          m_edges;
  int          m_ticks;
  logic [15:0] m_frame;
  logic [3:0]  m_dpf;
  logic        m_rst;

  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  sevenseg_scan_display #(.DIGITS(DIGITS), .REFRESH_DIV(DIV), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .digits(digits), .dp_in(dp_in), .blank(blank),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_slot();
    return (m_ticks - 1) % DIGITS;
  endfunction

  task automatic check_outputs(input string tag);
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    logic       lit;
    int         i;
    lit = 1'b0;
    i   = 0;
    if (!m_rst && m_ticks > 0 && !blank) begin
      i   = cur_slot();
      lit = 1'b1;
`ifdef SEVENSEG_LEADING_ZERO_BLANK_EN
      if (i > 0 && (m_frame >> (4 * i)) == 16'h0) lit = 1'b0;
`endif
    end
    if (lit) begin
      e_an  = ~(4'b0001 << i);
      e_seg = ~hex_tab[m_frame[4*i +: 4]];
      e_dp  = ~m_dpf[i];
    end else begin
      e_an  = 4'hF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
    end
    check({tag, ".an"},  32'(an),  32'(e_an));
    check({tag, ".seg"}, 32'(seg), 32'(e_seg));
    check({tag, ".dp"},  32'(dp),  32'(e_dp));
  endtask

  // advance the model by one clock edge using the inputs the DUT will sample
  task automatic model_edge();
    if (m_rst) return;
    m_edges++;
    if (m_edges % DIV == 0) begin
      m_ticks++;
      if (cur_slot() == 0) begin
        m_frame = digits;
        m_dpf   = dp_in;
      end
    end
  endtask

  task automatic model_reset();
    m_edges = 0;
    m_ticks = 0;
    m_frame = '0;
    m_dpf   = '0;
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // reset asserted between edges, checked before any edge, held through one edge
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    m_rst = 1'b1;
    model_reset();
    #1;
    check_outputs({tag, ".async"});
    @(posedge clk);
    #1;
    check_outputs({tag, ".held"});
    reset = 1'b0;
    m_rst = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    m_rst  = 1'b1;
    digits = 16'h0;
    dp_in  = 4'h0;
    blank  = 1'b0;
    model_reset();
    #1;
    check_outputs("rst0");
    @(posedge clk);
    #1;
    check_outputs("rst1");
    digits = 16'h1234;
    reset  = 1'b0;
    m_rst  = 1'b0;

    for (int k = 0; k < 40; k++) step("seq1234");

    // mid-frame change must wait for the next wrap
    while (!(m_ticks > 0 && cur_slot() == 2)) step("seek2");
    digits = 16'hABCD;
    for (int k = 0; k < 24; k++) step("midchg");

    // blank window across slot boundaries
    blank = 1'b1;
    for (int k = 0; k < 10; k++) step("blank");
    blank = 1'b0;
    for (int k = 0; k < 12; k++) step("unblank");

    // reset pulse in slot 2, then restart from the same frame input
    while (!(m_ticks > 0 && cur_slot() == 2)) step("seek2r");
    digits = 16'h1234;
    pulse_reset("rstpulse");
    for (int k = 0; k < 24; k++) step("restart");

    dp_in  = 4'b0100;
    digits = 16'h0008;
    for (int k = 0; k < 36; k++) step("dp8");

    dp_in  = 4'b0000;
    digits = 16'h0050;
    for (int k = 0; k < 36; k++) step("lz50");

    digits = 16'h0000;
    for (int k = 0; k < 36; k++) step("zero");

    // random traffic: inputs, blank and occasional resets
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) dp_in = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blank = ~blank;
      if ($urandom_range(0, 199) == 0) pulse_reset("rndrst");
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
